// File: rtl/max_pool_scheduler.sv
// max_pool_scheduler: fetches each XxY window of a stored map and emits its maximum over ready/valid
module max_unit #(
  parameter int DEPTH = 8,
  parameter int N = 9
) (
  input  logic [N-1:0][DEPTH-1:0] data_in,
  output logic [DEPTH-1:0]        data_out
);
  always_comb begin
    data_out = '0;
    for (int i = 0; i < N; i++) data_out = data_in[i] > data_out ? data_in[i] : data_out;
  end
endmodule

module max_pool_scheduler #(
  parameter int DEPTH = 8,
  parameter int X = 3,
  parameter int Y = 3,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DEPTH-1:0]  mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DEPTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr
);
  localparam int N = X * Y;
  localparam int PW = IMG_W / X;
  localparam int PH = IMG_H / Y;
  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(PW + 1);
  localparam int RW = $clog2(PH + 1);
  typedef enum logic [2:0] {IDLE, FETCH, LAST, EMIT, DONE} state_t;
  state_t state;
  logic [KW-1:0] k, cap_slot;
  logic cap_en;
  logic [CW-1:0] ocol, ncol;
  logic [RW-1:0] orow, nrow;
  logic [N-1:0][DEPTH-1:0] win;
  logic last_win;
  function automatic logic [ADDR_W-1:0] pix(input int r0, input int c0, input int kk);
    return ADDR_W'((r0 * Y + kk / X) * IMG_W + c0 * X + kk % X);
  endfunction
  assign last_win = orow == RW'(PH - 1) && ocol == CW'(PW - 1);
  assign ncol = ocol == CW'(PW - 1) ? '0 : ocol + CW'(1);
  assign nrow = ocol == CW'(PW - 1) ? orow + RW'(1) : orow;
  max_unit #(.DEPTH(DEPTH), .N(N)) u_max (.data_in(win), .data_out(out_data));
  // Read data lags its strobe by one cycle, so the slot to fill is carried alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      cap_slot <= '0;
      cap_en <= 1'b0;
      ocol <= '0;
      orow <= '0;
      win <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_rd_addr <= '0;
      out_valid <= 1'b0;
      out_addr <= '0;
    end else begin
      cap_en <= mem_rd_en;
      cap_slot <= KW'(N - 1) - k;
      if (cap_en) win[cap_slot] <= mem_rd_data;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          busy <= 1'b1;
          mem_rd_en <= 1'b1;
          mem_rd_addr <= pix(0, 0, 0);
          k <= '0;
          ocol <= '0;
          orow <= '0;
          out_addr <= '0;
        end
        FETCH: if (k == KW'(N - 1)) begin
          state <= LAST;
          mem_rd_en <= 1'b0;
        end else begin
          k <= k + KW'(1);
          mem_rd_addr <= pix(int'(orow), int'(ocol), int'(k) + 1);
        end
        LAST: begin
          state <= EMIT;
          out_valid <= 1'b1;
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          if (last_win) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= FETCH;
            mem_rd_en <= 1'b1;
            mem_rd_addr <= pix(int'(nrow), int'(ncol), 0);
            k <= '0;
            ocol <= ncol;
            orow <= nrow;
            out_addr <= ADDR_W'(int'(nrow) * PW + int'(ncol));
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_max_pool_scheduler.sv
// tb_max_pool_scheduler: directed frames checked against a window-maximum model and literal results
module tb_max_pool_scheduler;
  localparam int DEPTH = 8, X = 3, Y = 3, IMG_W = 6, IMG_H = 6, ADDR_W = 6;
  logic clk = 0, rst = 1, start = 0, out_ready = 1;
  logic busy, done, mem_rd_en, out_valid;
  logic [ADDR_W-1:0] mem_rd_addr, out_addr;
  logic [DEPTH-1:0] mem_rd_data = '0, out_data;
  logic [DEPTH-1:0] mem [1 << ADDR_W];
  typedef struct {int a; int d;} out_t;
  out_t exp_q[$];
  int rd_q[$];
  int log_a[$], log_d[$];
  int pass_cnt = 0, total_cnt = 0, done_cnt = 0, cyc = 0;
  logic stall_v = 0;
  int hold_a = 0, hold_d = 0;

  max_pool_scheduler #(.DEPTH(DEPTH), .X(X), .Y(Y), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic chk(input string n, input int a, input int e);
    total_cnt++;
    if (a == e) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask

  // Model: every read address and every window maximum, straight from the pooling definition
  task automatic plan_frame();
    int m, a;
    exp_q.delete(); rd_q.delete(); log_a.delete(); log_d.delete();
    for (int orow = 0; orow < IMG_H / Y; orow++)
      for (int ocol = 0; ocol < IMG_W / X; ocol++) begin
        m = 0;
        for (int r = 0; r < Y; r++)
          for (int c = 0; c < X; c++) begin
            a = (orow * Y + r) * IMG_W + ocol * X + c;
            rd_q.push_back(a);
            if (int'(mem[a]) > m) m = int'(mem[a]);
          end
        exp_q.push_back('{orow * (IMG_W / X) + ocol, m});
      end
  endtask

  always @(negedge clk) begin
    if (rst) stall_v = 0;
    else begin
      if (mem_rd_en) begin
        if (rd_q.size() == 0) chk("read_unexpected", int'(mem_rd_addr), -1);
        else chk("rd_addr", int'(mem_rd_addr), rd_q.pop_front());
      end
      if (out_valid) begin
        if (stall_v) begin
          chk("hold_data", int'(out_data), hold_d);
          chk("hold_addr", int'(out_addr), hold_a);
        end
        if (out_ready) begin
          log_a.push_back(int'(out_addr));
          log_d.push_back(int'(out_data));
          if (exp_q.size() == 0) chk("out_unexpected", int'(out_addr), -1);
          else begin
            out_t e;
            e = exp_q.pop_front();
            chk("out_addr", int'(out_addr), e.a);
            chk("out_data", int'(out_data), e.d);
          end
        end
      end else if (stall_v) chk("valid_dropped", 0, 1);
      stall_v = out_valid && !out_ready;
      hold_a = int'(out_addr);
      hold_d = int'(out_data);
      if (done) done_cnt++;
    end
  end

  task automatic pulse_start(output int fetch0);
    @(posedge clk); #1 start = 1;
    fetch0 = cyc + 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic finish_frame(input int fetch0, input int extra, input int done0);
    int dc;
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
    end
    chk("frame_len", dc - fetch0, 44 + extra);
    chk("busy_in_done", int'(busy), 1);
    @(negedge clk);
    chk("busy_after", int'(busy), 0);
    chk("done_after", int'(done), 0);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt - done0, 1);
    chk("outs_left", exp_q.size(), 0);
    chk("reads_left", rd_q.size(), 0);
    chk("out_count", log_d.size(), 4);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk({tag, "_rd_addr"}, int'(mem_rd_addr), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_data"}, int'(out_data), 0);
    chk({tag, "_addr"}, int'(out_addr), 0);
  endtask

  task automatic fill(input int mode);
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = mode == 0 ? DEPTH'(a) : mode == 1 ? 8'd255 : 8'd0;
  endtask

  initial begin
    int f0, d0, rise, fc;
    int w0[9] = '{10, 20, 5, 40, 15, 60, 25, 30, 50};
    int wa[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    int lit[4] = '{14, 17, 32, 35};
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1 rst = 0;

    // pixel[a] = a
    plan_frame();
    for (int i = 0; i < 4; i++) chk("model_pin", exp_q[i].d, lit[i]);
    d0 = done_cnt;
    pulse_start(f0);
    finish_frame(f0, 0, d0);
    for (int i = 0; i < 4; i++) begin
      chk("lit_addr", log_a[i], i);
      chk("lit_data", log_d[i], lit[i]);
    end

    // only window 0 populated
    fill(2);
    for (int i = 0; i < 9; i++) mem[wa[i]] = DEPTH'(w0[i]);
    plan_frame();
    d0 = done_cnt;
    pulse_start(f0);
    finish_frame(f0, 0, d0);
    chk("w0_data", log_d[0], 60);
    chk("w0_addr", log_a[0], 0);
    for (int i = 1; i < 4; i++) chk("w_rest_zero", log_d[i], 0);

    // stall the first EMIT for 5 cycles
    fill(0);
    plan_frame();
    d0 = done_cnt;
    out_ready = 0;
    pulse_start(f0);
    fc = 0;
    for (int i = 0; i < 50 && !fc; i++) begin @(negedge clk); fc = int'(out_valid); end
    chk("first_valid", fc, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 out_ready = 1;
    rise = cyc;
    fc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin fc = cyc; break; end
    end
    chk("refetch_cycle", fc, rise + 1);
    finish_frame(f0, 5, d0);

    // saturated frame, then all-zero frame
    fill(1);
    plan_frame();
    d0 = done_cnt;
    pulse_start(f0);
    finish_frame(f0, 0, d0);
    for (int i = 0; i < 4; i++) chk("sat_data", log_d[i], 255);
    fill(2);
    plan_frame();
    d0 = done_cnt;
    pulse_start(f0);
    finish_frame(f0, 0, d0);
    for (int i = 0; i < 4; i++) chk("zero_data", log_d[i], 0);

    // start pulsed again mid-frame
    fill(0);
    plan_frame();
    d0 = done_cnt;
    pulse_start(f0);
    repeat (20) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    finish_frame(f0, 0, d0);

    // reset during the third window's FETCH
    plan_frame();
    pulse_start(f0);
    fc = 0;
    for (int i = 0; i < 100 && !fc; i++) begin
      @(negedge clk);
      fc = int'(log_d.size() == 2 && mem_rd_en);
    end
    chk("third_fetch_seen", fc, 1);
    @(posedge clk); #1 rst = 1;
    exp_q.delete(); rd_q.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_idle_zero("mid_reset");
    plan_frame();
    d0 = done_cnt;
    pulse_start(f0);
    finish_frame(f0, 0, d0);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_addr", log_a[i], i);
      chk("post_rst_data", log_d[i], lit[i]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
